reg_scan_reader: RTL and testbench
==================================

// Module: reg_scan_reader
// PURPOSE
//  Debug read-side master for the register file's read port.
//  On a start command it walks a register index range [first_reg..last_reg].
//  It drives the read address, captures the returned word, and emits each word on a valid/ready stream.
//  Sits between the register file read port and the board debug/display path.
//  Register file writes occur on negedge CLK; this block samples on posedge CLK, so captured data is stable.
// PARAMETERS
//  DATA_W   32  width of a register word / out_data
//  ADDR_W   5   width of register index (32 registers)
// PORTS
//  CLK        in   1       clock, all state updates on posedge
//  RST        in   1       reset, asynchronous, active-low
//  start      in   1       begin scan; sampled only in IDLE
//  abort      in   1       cancel scan; priority over everything except RST
//  first_reg  in   ADDR_W  first index, sampled with start
//  last_reg   in   ADDR_W  last index (inclusive), sampled with start
//  rd_data    in   DATA_W  combinational read data for rd_addr (index 0 reads 0)
//  out_ready  in   1       downstream accepts word
//  rd_addr    out  ADDR_W  registered read index driven to the register file
//  out_valid  out  1       out_data/out_idx hold a word
//  out_data   out  DATA_W  captured register word
//  out_idx    out  ADDR_W  index of out_data
//  busy       out  1       high in any state except IDLE
//  done       out  1       one-cycle pulse at scan completion (not on abort)
// BEHAVIOUR
//  Reset (RST=0, any time, incl. mid-scan): state=IDLE.
//   rd_addr, out_data, out_idx, out_valid, busy and done all cleared to 0.
//   Latched first/last cleared; no done pulse is issued.
//  FSM states: IDLE, READ, SEND, FIN.
//  IDLE: on start=1:
//   - if first_reg<=last_reg: latch last_reg; rd_addr<=first_reg; go READ.
//   - if first_reg>last_reg: go FIN (empty scan, no words emitted).
//  READ: one cycle; out_data<=rd_data, out_idx<=rd_addr, out_valid<=1; go SEND.
//  SEND: hold out_valid and the data stable until out_valid&&out_ready.
//   On acceptance, out_valid<=0 in the same edge, then:
//   - if rd_addr==last: go FIN.
//   - else: rd_addr<=rd_addr+1; go READ.
//  FIN: done=1 for exactly this cycle; go IDLE.
//  Latency: start edge -> out_valid at 2nd posedge after start. Max throughput is 1 word per 2 cycles.
//  Index arithmetic is ADDR_W bits unsigned and never wraps.
//   last_reg=31 terminates on the compare, before the increment.
//  first_reg==last_reg: exactly one word, then done.
//  start while busy: ignored; range latches are unchanged.
//  abort=1 in any non-IDLE state: IDLE next edge.
//   out_valid<=0 even if unaccepted (the only permitted valid drop); no done pulse.
//  abort and start in the same IDLE cycle: abort wins and the scan does not begin.
//  out_ready is ignored while out_valid=0.
//  rd_data is sampled only in READ; a write to that register in the same cycle gives the negedge-written value.
// TESTING
//  1. Regs 1..3 = 0x11,0x22,0x33; start first=1,last=3, out_ready=1 -> 3 words (idx1..3) at 2-cycle spacing, then done pulse once.
//  2. Same scan with out_ready low 4 cycles on word 2 -> out_valid/out_data=0x22 held stable 4 cycles, no word lost or duplicated.
//  3. first=0,last=0 -> one word idx0 data 0; first=31,last=31 -> one word, rd_addr stays 31, done.
//  4. first=5,last=2 -> no out_valid, busy high 1 cycle, done pulse 2nd cycle after start.
//  5. abort during SEND of word 2 of a 1..3 scan -> out_valid=0 next edge, IDLE, no done; start ignored mid-scan.
//  6. RST low mid-scan (during READ and during SEND) -> all outputs 0 immediately (async); new scan after release behaves as test 1.

Source files
------------

// File: rtl/reg_scan_reader.sv
// Debug read master: walks register indices [first_reg..last_reg] over the register
// file read port and streams each captured word out on a valid/ready handshake.
module reg_scan_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | rd_addr presented, capture rd_data this edge
    // SEND  | word held on the stream until accepted
    // FIN   | done pulse, back to IDLE
    typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [ADDR_W-1:0]   last_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [ADDR_W-1:0]   out_idx_q;
    logic                out_valid_q;
    logic                busy_q;
    logic                done_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            last_q      <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != IDLE)) begin
                // Abort is the only path that may drop an unaccepted word.
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            busy_q <= 1'b1;
                            if (first_reg <= last_reg) begin
                                last_q    <= last_reg;
                                rd_addr_q <= first_reg;
                                state_q   <= READ;
                            end else begin
                                state_q <= FIN;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        out_data_q  <= rd_data;
                        out_idx_q   <= rd_addr_q;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                    SEND: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            // Compare before increment so last_reg at the top index never wraps.
                            if (rd_addr_q == last_q) begin
                                state_q <= FIN;
                                done_q  <= 1'b1;
                            end else begin
                                rd_addr_q <= rd_addr_q + 1'b1;
                                state_q   <= READ;
                            end
                        end
                    end
                    FIN: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_scan_reader.sv
// Directed bench for reg_scan_reader: register-file model, scoreboard of expected
// words checked at each handshake, plus timing, hold, abort and reset checks.
module tb_reg_scan_reader;

    logic        CLK;
    logic        RST;
    logic        start;
    logic        abort;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [31:0] rd_data;
    logic        out_ready;
    logic [4:0]  rd_addr;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } word_t;

    word_t       sb[$];
    logic [31:0] regs [32];
    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;

    logic        hold;
    logic [31:0] hold_data;
    logic [4:0]  hold_idx;

    reg_scan_reader #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .first_reg(first_reg), .last_reg(last_reg), .rd_data(rd_data),
        .out_ready(out_ready), .rd_addr(rd_addr), .out_valid(out_valid),
        .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done)
    );

    assign rd_data = (rd_addr == 5'd0) ? 32'd0 : regs[rd_addr];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pop on handshake, stability of an unaccepted word, done count.
    always @(negedge CLK) begin
        if (!RST) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(hold_data));
                chk("hold_idx", 64'(out_idx), 64'(hold_idx));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 64'(out_idx), 64'h1_0000);
                end else begin
                    word_t w;
                    w = sb.pop_front();
                    chk("word_idx", 64'(out_idx), 64'(w.idx));
                    chk("word_data", 64'(out_data), 64'(w.data));
                end
            end
            if (done) done_cnt++;
            hold      = out_valid && !out_ready && !abort;
            hold_data = out_data;
            hold_idx  = out_idx;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [4:0] f, input logic [4:0] l);
        word_t w;
        start     = 1'b1;
        first_reg = f;
        last_reg  = l;
        if (f <= l) begin
            for (int i = int'(f); i <= int'(l); i++) begin
                w.idx  = 5'(i);
                w.data = (i == 0) ? 32'd0 : regs[i];
                sb.push_back(w);
            end
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk(tag, 64'(done), 64'd1);
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_idx"}, 64'(out_idx), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // Full-rate 1..3 scan with exact per-cycle valid pattern.
    task automatic scan_1_3(input string tag);
        int d0;
        d0 = done_cnt;
        out_ready = 1'b1;
        do_start(5'd1, 5'd3);
        chk({tag, "_busy0"}, 64'(busy), 64'd1);
        chk({tag, "_valid0"}, 64'(out_valid), 64'd0);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk({tag, "_valid_pat"}, 64'(out_valid), 64'((i % 2 == 1) && (i <= 5)));
            if (i % 2 == 1 && i <= 5) chk({tag, "_idx_pat"}, 64'(out_idx), 64'((i + 1) / 2));
        end
        chk({tag, "_done_hi"}, 64'(done), 64'd1);
        step();
        chk({tag, "_done_lo"}, 64'(done), 64'd0);
        chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
        chk({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int d0;
        RST = 1'b0; start = 1'b0; abort = 1'b0;
        first_reg = '0; last_reg = '0; out_ready = 1'b1;
        hold = 1'b0; hold_data = '0; hold_idx = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);
        regs[1] = 32'h11; regs[2] = 32'h22; regs[3] = 32'h33; regs[31] = 32'hDEAD_BEEF;

        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        step();

        scan_1_3("t1");

        // Backpressure on word 2 for four cycles.
        d0 = done_cnt;
        do_start(5'd1, 5'd3);
        step();
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_valid", 64'(out_valid), 64'd1);
            chk("t2_data", 64'(out_data), 64'h22);
            chk("t2_idx", 64'(out_idx), 64'd2);
        end
        out_ready = 1'b1;
        wait_done("t2_done");
        chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Single-word scans at both ends of the index range.
        do_start(5'd0, 5'd0);
        wait_done("t3a_done");
        chk("t3a_rd_addr", 64'(rd_addr), 64'd0);
        chk("t3a_sb_empty", 64'(sb.size()), 64'd0);
        do_start(5'd31, 5'd31);
        wait_done("t3b_done");
        chk("t3b_rd_addr", 64'(rd_addr), 64'd31);
        step();
        chk("t3b_rd_addr_idle", 64'(rd_addr), 64'd31);
        chk("t3b_busy", 64'(busy), 64'd0);
        chk("t3b_sb_empty", 64'(sb.size()), 64'd0);

        // Empty range.
        d0 = done_cnt;
        do_start(5'd5, 5'd2);
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_valid", 64'(out_valid), 64'd0);
        chk("t4_done", 64'(done), 64'd1);
        step();
        chk("t4_busy_lo", 64'(busy), 64'd0);
        chk("t4_done_lo", 64'(done), 64'd0);
        chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Abort together with start in IDLE.
        abort = 1'b1; start = 1'b1; first_reg = 5'd1; last_reg = 5'd3;
        step();
        abort = 1'b0; start = 1'b0;
        chk("t5a_busy", 64'(busy), 64'd0);
        step();
        chk("t5a_valid", 64'(out_valid), 64'd0);

        // Start ignored mid-scan, then abort while word 2 is unaccepted.
        d0 = done_cnt;
        do_start(5'd1, 5'd3);
        start = 1'b1; first_reg = 5'd1; last_reg = 5'd1;
        step();
        step();
        start = 1'b0;
        out_ready = 1'b0;
        step();
        chk("t5_valid_w2", 64'(out_valid), 64'd1);
        chk("t5_idx_w2", 64'(out_idx), 64'd2);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_valid", 64'(out_valid), 64'd0);
        chk("t5_abort_busy", 64'(busy), 64'd0);
        chk("t5_abort_done", 64'(done), 64'd0);
        chk("t5_sb_left", 64'(sb.size()), 64'd2);
        sb.delete();
        out_ready = 1'b1;
        repeat (3) step();
        chk("t5_no_done", 64'(done_cnt - d0), 64'd0);

        // Asynchronous reset during READ.
        do_start(5'd1, 5'd3);
        #2 RST = 1'b0;
        #1 chk_all_zero("t6_read");
        sb.delete();
        step();
        #2 RST = 1'b1;
        step();

        // Asynchronous reset during SEND.
        do_start(5'd1, 5'd3);
        step();
        chk("t6_send_valid_pre", 64'(out_valid), 64'd1);
        #2 RST = 1'b0;
        #1 chk_all_zero("t6_send");
        sb.delete();
        step();
        #2 RST = 1'b1;
        step();

        scan_1_3("t6_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
